// File: rtl/coletor_8_numeros.sv
// Collects eight serial values through a valid/ready handshake and holds them as a parallel frame for the sorter.
// Optional macro COLETOR_PAD_EN: flush pads a partial frame with the order's extreme value instead of discarding it.
module coletor_8_numeros #(
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_cresc,
   input  logic             flush,
   input  logic             frame_ack,
   output logic             ena,
   output logic             cresc_ou_decres,
   output logic [WIDTH-1:0] n1_n,
   output logic [WIDTH-1:0] n2_n,
   output logic [WIDTH-1:0] n3_n,
   output logic [WIDTH-1:0] n4_n,
   output logic [WIDTH-1:0] n5_n,
   output logic [WIDTH-1:0] n6_n,
   output logic [WIDTH-1:0] n7_n,
   output logic [WIDTH-1:0] n8_n,
   output logic [3:0]       count
);

   typedef enum logic {
      COLLECT = 1'b0,
      FULL    = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] slot_q [8];
   logic [WIDTH-1:0] slot_d [8];
   logic [3:0]       count_q, count_d;
   logic [3:0]       count_acc;
   logic             cresc_q, cresc_d;
   logic             ena_q, ena_d;
   logic             in_ready_q, in_ready_d;
   logic             accept;

   // A flush is evaluated against the count after this cycle's accept, so a flush on the 8th value is a plain completion.
   always_comb begin
      state_d   = state_q;
      slot_d    = slot_q;
      count_d   = count_q;
      cresc_d   = cresc_q;
      count_acc = count_q;
      accept    = in_valid && in_ready_q;

      case (state_q)
         COLLECT: begin
            if (accept) begin
               for (int i = 0; i < 8; i++) begin
                  if (count_q == 4'(i)) begin
                     slot_d[i] = in_data;
                  end
               end
               count_acc = count_q + 4'd1;
               if (count_q == 4'd0) begin
                  cresc_d = in_cresc;
               end
            end
            count_d = count_acc;
            if (count_acc == 4'd8) begin
               state_d = FULL;
            end else if (flush && (count_acc != 4'd0)) begin
`ifdef COLETOR_PAD_EN
               for (int i = 0; i < 8; i++) begin
                  if (4'(i) >= count_acc) begin
                     slot_d[i] = cresc_d ? '0 : '1;
                  end
               end
               state_d = FULL;
`else
               for (int i = 0; i < 8; i++) begin
                  slot_d[i] = '0;
               end
               count_d = 4'd0;
`endif
            end
         end
         FULL: begin
            if (frame_ack) begin
               for (int i = 0; i < 8; i++) begin
                  slot_d[i] = '0;
               end
               count_d = 4'd0;
               state_d = COLLECT;
            end
         end
         default: begin
            state_d = COLLECT;
         end
      endcase

      ena_d      = (state_d == FULL);
      in_ready_d = (state_d == COLLECT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= COLLECT;
         count_q    <= 4'd0;
         cresc_q    <= 1'b0;
         ena_q      <= 1'b0;
         in_ready_q <= 1'b1;
         for (int i = 0; i < 8; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         cresc_q    <= cresc_d;
         ena_q      <= ena_d;
         in_ready_q <= in_ready_d;
         for (int i = 0; i < 8; i++) begin
            slot_q[i] <= slot_d[i];
         end
      end
   end

   assign in_ready        = in_ready_q;
   assign ena             = ena_q;
   assign cresc_ou_decres = cresc_q;
   assign count           = count_q;
   assign n1_n            = slot_q[0];
   assign n2_n            = slot_q[1];
   assign n3_n            = slot_q[2];
   assign n4_n            = slot_q[3];
   assign n5_n            = slot_q[4];
   assign n6_n            = slot_q[5];
   assign n7_n            = slot_q[6];
   assign n8_n            = slot_q[7];

endmodule

// File: tb/tb_coletor_8_numeros.sv
// Self-checking bench for coletor_8_numeros: directed frames plus random traffic against a queue-based frame model.
// Works with or without COLETOR_PAD_EN defined.
module tb_coletor_8_numeros;

   localparam int WIDTH = 9;
   localparam int MAXV  = (1 << WIDTH) - 1;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_cresc;
   logic             flush;
   logic             frame_ack;
   logic             ena;
   logic             cresc_ou_decres;
   logic [WIDTH-1:0] n1_n, n2_n, n3_n, n4_n, n5_n, n6_n, n7_n, n8_n;
   logic [3:0]       count;
   logic [WIDTH-1:0] dut_n [8];

   int n_checks;
   int n_fail;

   // Reference model: the frame is the list of accepted values, optionally padded, plus a "presented" flag.
   int unsigned m_vals[$];
   bit          m_full;
   bit          m_padded;
   bit          m_cresc;

   coletor_8_numeros #(.WIDTH(WIDTH)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_data         (in_data),
      .in_cresc        (in_cresc),
      .flush           (flush),
      .frame_ack       (frame_ack),
      .ena             (ena),
      .cresc_ou_decres (cresc_ou_decres),
      .n1_n            (n1_n),
      .n2_n            (n2_n),
      .n3_n            (n3_n),
      .n4_n            (n4_n),
      .n5_n            (n5_n),
      .n6_n            (n6_n),
      .n7_n            (n7_n),
      .n8_n            (n8_n),
      .count           (count)
   );

   assign dut_n[0] = n1_n;
   assign dut_n[1] = n2_n;
   assign dut_n[2] = n3_n;
   assign dut_n[3] = n4_n;
   assign dut_n[4] = n5_n;
   assign dut_n[5] = n6_n;
   assign dut_n[6] = n7_n;
   assign dut_n[7] = n8_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      m_vals.delete();
      m_full   = 1'b0;
      m_padded = 1'b0;
      m_cresc  = 1'b0;
   endtask

   function automatic int unsigned expSlot(input int i);
      if (i < m_vals.size()) return m_vals[i];
      if (m_padded) return m_cresc ? 0 : MAXV;
      return 0;
   endfunction

   // One clock edge of the frame rules, applied to the model.
   task automatic modelEdge(input bit v, input int unsigned d, input bit c, input bit f, input bit a);
      if (!m_full) begin
         if (v) begin
            if (m_vals.size() == 0) m_cresc = c;
            m_vals.push_back(d);
         end
         if (m_vals.size() == 8) begin
            m_full = 1'b1;
         end else if (f && m_vals.size() > 0) begin
`ifdef COLETOR_PAD_EN
            m_full   = 1'b1;
            m_padded = 1'b1;
`else
            m_vals.delete();
`endif
         end
      end else if (a) begin
         m_vals.delete();
         m_full   = 1'b0;
         m_padded = 1'b0;
      end
   endtask

   task automatic checkOutput(input string tag);
      check({tag, "_ena"}, ena, m_full);
      check({tag, "_in_ready"}, in_ready, !m_full);
      check({tag, "_count"}, count, m_vals.size());
      check({tag, "_cresc"}, cresc_ou_decres, m_cresc);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("%s_n%0d", tag, i + 1), dut_n[i], expSlot(i));
      end
   endtask

   // Check the current outputs at the falling edge, then drive one cycle of inputs.
   task automatic applyStimulus(input string tag, input bit v, input int unsigned d,
                                input bit c, input bit f, input bit a);
      @(negedge clk);
      checkOutput(tag);
      in_valid  = v;
      in_data   = WIDTH'(d);
      in_cresc  = c;
      flush     = f;
      frame_ack = a;
      modelEdge(v, d, c, f, a);
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_cresc  = 1'b0;
      flush     = 1'b0;
      frame_ack = 1'b0;
      modelReset();

      @(negedge clk);
      check("reset_ena", ena, 0);
      check("reset_in_ready", in_ready, 1);
      check("reset_count", count, 0);
      checkOutput("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Frame 1..8 ascending on consecutive cycles
      for (int k = 1; k <= 8; k++) applyStimulus("f1", 1'b1, k, 1'b0, 1'b0, 1'b0);
      applyStimulus("f1_full", 1'b0, 0, 1'b0, 1'b0, 1'b0);
      check("f1_ena_const", ena, 1);
      check("f1_n1_const", n1_n, 1);
      check("f1_n8_const", n8_n, 8);
      check("f1_count_const", count, 8);
      applyStimulus("f1_ack", 1'b0, 0, 1'b0, 1'b0, 1'b1);

      // Frame 8..1 descending, valid every other cycle, ack withheld
      for (int k = 0; k < 16; k++) begin
         applyStimulus("f2", (k % 2) == 0, 8 - k / 2, k == 0, 1'b0, 1'b0);
      end
      for (int k = 0; k < 5; k++) applyStimulus("f2_hold", 1'b0, 0, 1'b0, 1'b0, 1'b0);
      check("f2_cresc_const", cresc_ou_decres, 1);
      check("f2_n1_const", n1_n, 8);
      applyStimulus("f2_ack", 1'b0, 0, 1'b0, 1'b0, 1'b1);
      applyStimulus("f2_after", 1'b0, 0, 1'b0, 1'b0, 1'b0);
      check("f2_after_ena_const", ena, 0);
      check("f2_after_n1_const", n1_n, 0);

      // FULL ignores data and flush; back-to-back frames after ack
      for (int k = 0; k < 8; k++) applyStimulus("f3", 1'b1, 100 + k, 1'b0, 1'b0, 1'b0);
      applyStimulus("f3_flush_full", 1'b1, 7, 1'b1, 1'b1, 1'b0);
      applyStimulus("f3_ack", 1'b0, 0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 8; k++) applyStimulus("f4", 1'b1, 200 + k, k == 0, 1'b0, k == 7);
      applyStimulus("f4_ack", 1'b0, 0, 1'b0, 1'b0, 1'b1);

      // Partial frame 5,9,2 then flush
      applyStimulus("f5", 1'b1, 5, 1'b0, 1'b0, 1'b0);
      applyStimulus("f5", 1'b1, 9, 1'b0, 1'b0, 1'b0);
      applyStimulus("f5", 1'b1, 2, 1'b0, 1'b0, 1'b0);
      applyStimulus("f5_flush", 1'b0, 0, 1'b0, 1'b1, 1'b0);
      applyStimulus("f5_after", 1'b0, 0, 1'b0, 1'b0, 1'b0);
`ifdef COLETOR_PAD_EN
      check("f5_pad_n4_const", n4_n, MAXV);
      check("f5_pad_count_const", count, 3);
`else
      check("f5_drop_count_const", count, 0);
      check("f5_drop_ena_const", ena, 0);
`endif
      applyStimulus("f5_ack", 1'b0, 0, 1'b0, 1'b0, 1'b1);

      // Asynchronous reset mid-frame
      for (int k = 0; k < 6; k++) applyStimulus("f6", 1'b1, 50 + k, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      flush     = 1'b0;
      frame_ack = 1'b0;
      #1;
      modelReset();
      check("midreset_count", count, 0);
      check("midreset_n1", n1_n, 0);
      check("midreset_ena", ena, 0);
      checkOutput("midreset");
      #2 rst_n = 1'b1;
      for (int k = 0; k < 8; k++) applyStimulus("f7", 1'b1, 300 + k, 1'b0, 1'b0, 1'b0);
      applyStimulus("f7_ack", 1'b0, 0, 1'b0, 1'b0, 1'b1);

      // Flush together with the 8th accept is a plain completion
      for (int k = 0; k < 8; k++) applyStimulus("f8", 1'b1, 400 + k, 1'b0, k == 7, 1'b0);
      applyStimulus("f8_full", 1'b0, 0, 1'b0, 1'b0, 1'b0);
      check("f8_count_const", count, 8);
      check("f8_n8_const", n8_n, 407);
      applyStimulus("f8_ack", 1'b0, 0, 1'b0, 1'b0, 1'b1);

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         applyStimulus("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, MAXV),
                       $urandom_range(0, 1) == 1, $urandom_range(0, 11) == 0,
                       $urandom_range(0, 2) == 0);
      end
      applyStimulus("final", 1'b0, 0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
